i2c_bus_filter: RTL

// Pad-side input stage directly upstream of the I2C controller. It synchronises the raw SCL/SDA
// pad inputs and removes glitches with a programmable stable-time filter. The filtered levels

---
 rtl/i2c_bus_filter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/i2c_bus_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_filter
// Description : Pad-side SCL/SDA synchroniser and stable-time glitch filter,
//               with SCL edge, START/STOP strobes and a bus-busy flag.
//               Optional glitch counter: define I2C_BUS_FILTER_GLITCH_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_filter #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_W     = 4,
    parameter int GLITCH_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [FILTER_W-1:0]     filt_len_i,
    input  logic                    scl_pad_i,
    input  logic                    sda_pad_i,
    output logic                    scl_o,
    output logic                    sda_o,
    output logic                    scl_rise_o,
    output logic                    scl_fall_o,
    output logic                    start_o,
    output logic                    stop_o,
    output logic                    bus_busy_o,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

    // Line index 0 is SCL, index 1 is SDA.
    logic [1:0] w_pad;
    logic [1:0] w_sync;
    logic [1:0] w_filt;
    logic [1:0] w_q;
`ifdef I2C_BUS_FILTER_GLITCH_CNT_EN
    logic [1:0] w_cnt_nz;
`endif
    logic       r_busy;

    assign w_pad = {sda_pad_i, scl_pad_i};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_line
            logic [SYNC_STAGES-1:0] r_sync;
            logic [FILTER_W-1:0]    r_cnt;
            logic                   r_out;
            logic                   r_q;

            // Synchroniser keeps running while the filter is disabled.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad[g]};
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_out <= 1'b1;
                    r_q   <= 1'b1;
                    r_cnt <= '0;
                end else if (!enable_i) begin
                    r_out <= 1'b1;
                    r_q   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_q <= r_out;
                    if (r_sync[SYNC_STAGES-1] == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= filt_len_i) begin
                        // Compare (not equality) so a shortened filt_len_i
                        // accepts a long-pending level immediately.
                        r_out <= r_sync[SYNC_STAGES-1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + {{(FILTER_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            assign w_sync[g] = r_sync[SYNC_STAGES-1];
            assign w_filt[g] = r_out;
            assign w_q[g]    = r_q;
`ifdef I2C_BUS_FILTER_GLITCH_CNT_EN
            assign w_cnt_nz[g] = |r_cnt;
`endif
        end
    endgenerate

    assign scl_o = w_filt[0];
    assign sda_o = w_filt[1];

    // An SCL transition masks START/STOP because both require SCL high in
    // the current and previous cycle.
    assign scl_rise_o = enable_i &  w_filt[0] & ~w_q[0];
    assign scl_fall_o = enable_i & ~w_filt[0] &  w_q[0];
    assign start_o    = enable_i & w_filt[0] & w_q[0] &  w_q[1] & ~w_filt[1];
    assign stop_o     = enable_i & w_filt[0] & w_q[0] & ~w_q[1] &  w_filt[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= 1'b0;
        end else if (!enable_i) begin
            r_busy <= 1'b0;
        end else if (start_o) begin
            r_busy <= 1'b1;
        end else if (stop_o) begin
            r_busy <= 1'b0;
        end
    end

    assign bus_busy_o = r_busy;

`ifdef I2C_BUS_FILTER_GLITCH_CNT_EN
    logic [1:0]              w_glitch;
    logic [GLITCH_CNT_W:0]   w_glitch_sum;
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    // A glitch is a pending level that vanished before being accepted.
    assign w_glitch     = {2{enable_i}} & w_cnt_nz & ~(w_sync ^ w_filt);
    assign w_glitch_sum = {1'b0, r_glitch_cnt}
                        + {{GLITCH_CNT_W{1'b0}}, w_glitch[0]}
                        + {{GLITCH_CNT_W{1'b0}}, w_glitch[1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_glitch_cnt <= '0;
        end else if (!enable_i) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch_sum[GLITCH_CNT_W]) begin
            r_glitch_cnt <= '1;
        end else begin
            r_glitch_cnt <= w_glitch_sum[GLITCH_CNT_W-1:0];
        end
    end

    assign glitch_cnt_o = r_glitch_cnt;
`else
    assign glitch_cnt_o = '0;
`endif

endmodule
`default_nettype wire
